uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver and upstream of the binary-to-BCD display path. It captures every completed RX byte, with its parity/stop error flags, into a circular FIFO, so bytes arriving faster than the consumer drains them are not lost. It reports occupancy and flags overflow. The consumer pops bytes with a registered read.

---
 rtl/uart_rx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Circular FIFO that buffers UART RX bytes and their error flags,
//               with occupancy, sticky overflow and a registered pop port.
//               Optional UART_RX_FIFO_ERR_DROP_EN discards error bytes and
//               counts them on drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_parity_err,
    input  logic                  wr_stop_err,
    input  logic                  rd_en,
    input  logic                  ovf_clr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_err,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam logic [DEPTH_LOG2:0] c_DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

    logic [DATA_W:0]       r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_rd_err;
    logic                  r_rd_valid;

    logic                  w_is_err;
    logic                  w_entry_err;
    logic                  w_wr_req;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_set;

    assign w_is_err = wr_parity_err | wr_stop_err;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    logic [7:0] r_drop_cnt;

    // Error bytes never reach the FIFO, so they can neither be stored nor overflow.
    assign w_wr_req    = wr_valid & ~w_is_err;
    assign w_entry_err = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= 8'd0;
        end else if (wr_valid && w_is_err && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign w_wr_req    = wr_valid;
    assign w_entry_err = w_is_err;
    assign drop_cnt    = 8'd0;
`endif

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_rd_acc  = rd_en & ~w_empty;
    // A write into a full FIFO is accepted only when a read frees a slot this cycle.
    assign w_wr_acc  = w_wr_req & (~w_full | w_rd_acc);
    assign w_ovf_set = w_wr_req & ~w_wr_acc;

    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {w_entry_err, wr_data};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr][DATA_W-1:0];
                r_rd_err  <= r_mem[r_rd_ptr][DATA_W];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_err   = r_rd_err;
    assign rd_valid = r_rd_valid;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench for uart_rx_fifo; honours
//               UART_RX_FIFO_ERR_DROP_EN when it is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_DEPTH = 16;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam bit c_DROP = 1'b1;
`else
    localparam bit c_DROP = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_parity_err;
    logic       wr_stop_err;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] drop_cnt;

    uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_parity_err (wr_parity_err),
        .wr_stop_err   (wr_stop_err),
        .rd_en         (rd_en),
        .ovf_clr       (ovf_clr),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    int         m_cnt    = 0;
    bit         m_ovf    = 1'b0;
    int         m_drop   = 0;
    logic [7:0] m_last   = 8'h00;
    logic       m_last_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_data = 8'h00; wr_parity_err = 1'b0;
        wr_stop_err = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    endtask

    // One clock with the given stimulus, then compare every output with the model.
    task automatic cycle(input logic wv, input logic [7:0] d, input logic perr,
                         input logic serr, input logic re, input logic clr);
        logic err, rd_acc, wr_req, wr_acc, ovf_set;
        logic [8:0] e;
        wr_valid = wv; wr_data = d; wr_parity_err = perr;
        wr_stop_err = serr; rd_en = re; ovf_clr = clr;
        err     = perr | serr;
        rd_acc  = re && (m_cnt != 0);
        wr_req  = wv && !(c_DROP && err);
        wr_acc  = wr_req && ((m_cnt < c_DEPTH) || rd_acc);
        ovf_set = wr_req && !wr_acc;
        if (wv && c_DROP && err && m_drop != 255) m_drop++;
        if (wr_acc) exp_q.push_back({(c_DROP ? 1'b0 : err), d});
        m_cnt = m_cnt + int'(wr_acc) - int'(rd_acc);
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clock);
        #1;
        if (rd_acc) begin
            e = exp_q.pop_front();
            m_last = e[7:0];
            m_last_err = e[8];
        end
        check("rd_valid", rd_valid, rd_acc);
        check("rd_data",  rd_data,  m_last);
        check("rd_err",   rd_err,   m_last_err);
        check("count",    count,    m_cnt);
        check("empty",    empty,    m_cnt == 0);
        check("full",     full,     m_cnt == c_DEPTH);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
        idle_inputs();
    endtask

    task automatic wr(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"},  rd_data,  0);
        check({tag, "_rd_err"},   rd_err,   0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_empty"},    empty,    1);
        check({tag, "_full"},     full,     0);
        check({tag, "_count"},    count,    0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    // Assert reset between clock edges with a write in flight; outputs must clear at once.
    task automatic async_reset();
        @(posedge clock);
        #3;
        wr_valid = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        m_cnt = 0; m_ovf = 1'b0; m_drop = 0; m_last = 8'h00; m_last_err = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        idle_inputs();
        check_reset_values("rst_hold");
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        // Basic ordered write then read.
        wr(8'h41); wr(8'h42); wr(8'h43);
        rd(); rd(); rd();
        check("basic_empty", empty, 1);

        // Fill, overflow, set-beats-clear, drain, clear.
        for (int i = 0; i < 16; i++) wr(8'(i));
        check("fill_count", count, 16);
        wr(8'hAA);
        check("ovf_set", overflow, 1);
        cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_set_wins", overflow, 1);
        for (int i = 0; i < 16; i++) rd();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 16; i++) wr(8'(i));
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_rw_data", rd_data, 8'h00);
        check("full_rw_count", count, 16);
        for (int i = 0; i < 16; i++) rd();
        check("full_rw_last", rd_data, 8'h55);

        // Empty FIFO with simultaneous write and read: no fall-through.
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        check("empty_rw_valid", rd_valid, 0);
        check("empty_rw_count", count, 1);
        rd();
        check("empty_rw_data", rd_data, 8'h77);

        // Error bytes: parity then stop-bit.
        cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        rd();
        cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        wr(8'h3C);
        rd(); rd();

        // Error byte into a full FIFO.
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        cycle(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) rd();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Twenty writes across a pointer wrap with interleaved reads, then reset mid-stream.
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, (i % 2) == 1, 1'b0);
        async_reset();
        wr(8'hC3);
        rd();
        check("post_rst_data", rd_data, 8'hC3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 55), 8'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 7) == 0));
        end
        while (m_cnt != 0) rd();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
